// File: rtl/jacobi_pkg.sv
// Shared types and default sizing for the Jacobi iteration sequencer.
package jacobi_pkg;

   localparam int unsigned JACOBI_N_ROWS     = 16;
   localparam int unsigned JACOBI_PIPE_DEPTH = 13;
   localparam int unsigned JACOBI_ITER_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_WAIT_DIV = 3'd3,
      ST_CHECK    = 3'd4,
      ST_DONE     = 3'd5
   } jacobi_state_t;

endpackage

// File: rtl/row_addr_gen.sv
// Loadable up/down counter with terminal-count flag; used for row issue and drain timing.
module row_addr_gen import jacobi_pkg::*; #(
   parameter int unsigned W          = 4,
   parameter bit          COUNT_DOWN = 1'b0,
   parameter int unsigned TC_VAL     = 0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   localparam logic [W-1:0] TC = W'(TC_VAL);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = COUNT_DOWN ? (cnt_q - W'(1)) : (cnt_q + W'(1));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/jacobi_iter_ctrl.sv
// Jacobi iteration sequencer: row issue, pipeline drain, divider wait and convergence/limit check.
module jacobi_iter_ctrl import jacobi_pkg::*; #(
   parameter int unsigned N_ROWS     = JACOBI_N_ROWS,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned PIPE_DEPTH = JACOBI_PIPE_DEPTH,
   parameter int unsigned ITER_W     = JACOBI_ITER_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ITER_W-1:0] max_iter,
   input  logic              dividor_done,
   input  logic              converged,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              row_last,
   output logic              buf_sel,
   output logic              clr_conv,
   output logic              iter_done,
   output logic [ITER_W-1:0] iter_count,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   jacobi_state_t state_q, state_d;
   logic [ITER_W-1:0] limit_q, limit_d;
   logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
   logic              buf_sel_q, buf_sel_d;
   logic              timeout_q, timeout_d;
   logic              clr_conv_q, clr_conv_d;

   logic              row_clr, row_en, row_tc;
   logic [ADDR_W-1:0] row_cnt;
   logic              drn_load, drn_en, drn_tc;
   logic [DRAIN_W-1:0] drn_cnt;

   row_addr_gen #(
      .W          (ADDR_W),
      .COUNT_DOWN (1'b0),
      .TC_VAL     (N_ROWS - 1)
   ) u_row_cnt (
      .clk_i      (clock),
      .rst_ni     (reset),
      .clr_i      (row_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .en_i       (row_en),
      .cnt_o      (row_cnt),
      .tc_o       (row_tc)
   );

   row_addr_gen #(
      .W          (DRAIN_W),
      .COUNT_DOWN (1'b1),
      .TC_VAL     (0)
   ) u_drain_cnt (
      .clk_i      (clock),
      .rst_ni     (reset),
      .clr_i      (1'b0),
      .load_i     (drn_load),
      .load_val_i (DRAIN_W'(PIPE_DEPTH - 1)),
      .en_i       (drn_en),
      .cnt_o      (drn_cnt),
      .tc_o       (drn_tc)
   );

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      iter_cnt_d = iter_cnt_q;
      buf_sel_d  = buf_sel_q;
      timeout_d  = timeout_q;
      clr_conv_d = 1'b0;
      row_clr    = 1'b0;
      row_en     = 1'b0;
      drn_load   = 1'b0;
      drn_en     = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               limit_d    = (max_iter == '0) ? ITER_W'(1) : max_iter;
               iter_cnt_d = '0;
               buf_sel_d  = 1'b0;
               timeout_d  = 1'b0;
               row_clr    = 1'b1;
               clr_conv_d = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            row_en = !row_tc;
            if (row_tc) begin
               drn_load = 1'b1;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drn_tc) begin
               state_d = ST_WAIT_DIV;
            end else begin
               drn_en = 1'b1;
            end
         end
         ST_WAIT_DIV: begin
            if (dividor_done) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // Saturating; the limit check below always fires before all-ones can wrap.
            iter_cnt_d = (iter_cnt_q == '1) ? iter_cnt_q : (iter_cnt_q + ITER_W'(1));
            if (converged) begin
               state_d = ST_DONE;
            end else if (iter_cnt_d == limit_q) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               buf_sel_d  = !buf_sel_q;
               clr_conv_d = 1'b1;
               row_clr    = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         limit_q    <= ITER_W'(1);
         iter_cnt_q <= '0;
         buf_sel_q  <= 1'b0;
         timeout_q  <= 1'b0;
         clr_conv_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         iter_cnt_q <= iter_cnt_d;
         buf_sel_q  <= buf_sel_d;
         timeout_q  <= timeout_d;
         clr_conv_q <= clr_conv_d;
      end
   end

   assign rd_en      = (state_q == ST_ISSUE);
   assign rd_addr    = rd_en ? row_cnt : '0;
   assign row_last   = rd_en && row_tc;
   assign buf_sel    = buf_sel_q;
   assign clr_conv   = clr_conv_q;
   assign iter_done  = (state_q == ST_CHECK);
   assign iter_count = iter_cnt_q;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_jacobi_iter_ctrl.sv
// Directed scoreboard bench for jacobi_iter_ctrl with N_ROWS=4, PIPE_DEPTH=13.
module tb_jacobi_iter_ctrl;

   localparam int NR = 4;
   localparam int PD = 13;
   localparam int PERIOD_IT = NR + PD + 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] max_iter;
   logic       dividor_done;
   logic       converged;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic       row_last;
   logic       buf_sel;
   logic       clr_conv;
   logic       iter_done;
   logic [7:0] iter_count;
   logic       busy;
   logic       done;
   logic       timeout;

   jacobi_iter_ctrl #(
      .N_ROWS     (NR),
      .ADDR_W     (4),
      .PIPE_DEPTH (PD),
      .ITER_W     (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .max_iter     (max_iter),
      .dividor_done (dividor_done),
      .converged    (converged),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .row_last     (row_last),
      .buf_sel      (buf_sel),
      .clr_conv     (clr_conv),
      .iter_done    (iter_done),
      .iter_count   (iter_count),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout)
   );

   always #5 clock = ~clock;

   typedef struct { int cyc; logic [3:0] addr; logic last; } rd_exp_t;
   typedef struct { int cyc; logic bsel; logic [7:0] cnt; } it_exp_t;

   rd_exp_t rd_q[$];
   it_exp_t it_q[$];
   int      clr_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;
   int done_at;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_iter(input int off, input logic bsel, input logic [7:0] cnt);
      rd_exp_t r;
      it_exp_t it;
      for (int i = 0; i < NR; i++) begin
         r.cyc  = off + i + 1;
         r.addr = 4'(i);
         r.last = (i == NR - 1);
         rd_q.push_back(r);
      end
      it.cyc  = off + PERIOD_IT;
      it.bsel = bsel;
      it.cnt  = cnt;
      it_q.push_back(it);
      clr_q.push_back(off + 1);
   endtask

   // Scoreboard monitor: every strobe must match the next queued expectation.
   always @(negedge clock) begin
      if (rd_en || row_last) begin
         check("rd_pending", rd_q.size() > 0, 1);
         if (rd_q.size() > 0) begin
            rd_exp_t r;
            r = rd_q.pop_front();
            check("rd_cycle", cyc - base, r.cyc);
            check("rd_en", rd_en, 1'b1);
            check("rd_addr", rd_addr, r.addr);
            check("row_last", row_last, r.last);
         end
      end
      if (iter_done) begin
         check("it_pending", it_q.size() > 0, 1);
         if (it_q.size() > 0) begin
            it_exp_t it;
            it = it_q.pop_front();
            check("iter_done_cycle", cyc - base, it.cyc);
            check("iter_buf_sel", buf_sel, it.bsel);
            check("iter_count_at_done", iter_count, it.cnt);
         end
      end
      if (clr_conv) begin
         check("clr_pending", clr_q.size() > 0, 1);
         if (clr_q.size() > 0) check("clr_conv_cycle", cyc - base, clr_q.pop_front());
      end
   end

   task automatic start_solve(input logic [7:0] mi);
      @(negedge clock);
      start    = 1'b1;
      max_iter = mi;
      @(posedge clock);
      #1;
      base     = cyc - 1;
      start    = 1'b0;
      max_iter = ~mi;
   endtask

   task automatic wait_rel(input int n);
      while (cyc - base < n) @(negedge clock);
   endtask

   task automatic wait_done(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clock);
         if (done) begin
            at = cyc - base;
            break;
         end
      end
      check("done_reached", done, 1'b1);
   endtask

   task automatic check_queues_empty();
      check("rd_q_empty", rd_q.size(), 0);
      check("it_q_empty", it_q.size(), 0);
      check("clr_q_empty", clr_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, rd_en, 1'b0);
      check({tag, "_rd_addr"}, rd_addr, 4'd0);
      check({tag, "_row_last"}, row_last, 1'b0);
      check({tag, "_clr_conv"}, clr_conv, 1'b0);
      check({tag, "_iter_done"}, iter_done, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_timeout"}, timeout, 1'b0);
      check({tag, "_buf_sel"}, buf_sel, 1'b0);
      check({tag, "_iter_count"}, iter_count, 8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      max_iter     = 8'd0;
      dividor_done = 1'b1;
      converged    = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clock);

      // Single converged iteration.
      converged = 1'b1;
      push_iter(0, 1'b0, 8'd0);
      start_solve(8'd5);
      wait_done(100, done_at);
      check("single_done_cycle", done_at, PERIOD_IT + 1);
      check("single_count", iter_count, 8'd1);
      check("single_timeout", timeout, 1'b0);
      check("single_busy", busy, 1'b0);
      check_queues_empty();

      // Convergence beats timeout when the limit is reached in the same check.
      push_iter(0, 1'b0, 8'd0);
      start_solve(8'd1);
      wait_done(100, done_at);
      check("prio_timeout", timeout, 1'b0);
      check("prio_count", iter_count, 8'd1);
      check_queues_empty();

      // Timeout after three iterations with bank toggling.
      converged = 1'b0;
      for (int k = 0; k < 3; k++) push_iter(k * PERIOD_IT, 1'(k % 2), 8'(k));
      start_solve(8'd3);
      wait_done(200, done_at);
      check("to_done_cycle", done_at, 3 * PERIOD_IT + 1);
      check("to_timeout", timeout, 1'b1);
      check("to_count", iter_count, 8'd3);
      check("to_buf_sel", buf_sel, 1'b0);
      repeat (5) @(negedge clock);
      check("to_hold_done", done, 1'b1);
      check("to_hold_timeout", timeout, 1'b1);
      check("to_hold_count", iter_count, 8'd3);
      check("to_hold_buf", buf_sel, 1'b0);
      check_queues_empty();

      // Divider stall with an ignored start while busy.
      converged    = 1'b1;
      dividor_done = 1'b0;
      push_iter(0, 1'b0, 8'd0);
      it_q[0].cyc = 31;
      start_solve(8'd5);
      wait_rel(10);
      check("ign_busy", busy, 1'b1);
      start = 1'b1;
      wait_rel(11);
      start = 1'b0;
      wait_rel(29);
      check("stall_waiting", busy, 1'b1);
      @(posedge clock);
      #1;
      dividor_done = 1'b1;
      wait_done(100, done_at);
      check("stall_done_cycle", done_at, 32);
      check("stall_count", iter_count, 8'd1);
      check_queues_empty();

      // Restart from DONE with max_iter=0: one iteration then timeout.
      converged = 1'b0;
      push_iter(0, 1'b0, 8'd0);
      start_solve(8'd0);
      check("restart_count_clr", iter_count, 8'd0);
      check("restart_clr_conv", clr_conv, 1'b1);
      check("restart_rd_en", rd_en, 1'b1);
      wait_done(100, done_at);
      check("mi0_done_cycle", done_at, PERIOD_IT + 1);
      check("mi0_timeout", timeout, 1'b1);
      check("mi0_count", iter_count, 8'd1);
      check_queues_empty();

      // Asynchronous reset in the middle of the drain interval.
      begin
         rd_exp_t r;
         for (int i = 0; i < NR; i++) begin
            r.cyc  = i + 1;
            r.addr = 4'(i);
            r.last = (i == NR - 1);
            rd_q.push_back(r);
         end
         clr_q.push_back(1);
      end
      start_solve(8'd5);
      wait_rel(8);
      check("drain_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check_all_zero("async_rst");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_done", done, 1'b0);
      check_queues_empty();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
